bp_stall_profile_counters: RTL and testbench

//  Consumer end of the per-cycle stall-reason stream emitted by the core profiler. Each cycle it

---
 rtl/bp_profiler_pkg.sv | 91 +++++++++
 rtl/bp_stall_reason_decode.sv | 27 ++
 rtl/bp_stall_profile_counters.sv | 129 ++++++++++++
 tb/tb_bp_stall_profile_counters.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_profiler_pkg.sv
// Shared types for the stall profiler: stall-reason codes, the packed per-cycle reason
// vector, the extra counter addresses and the stage-1 entry carried between pipeline stages.
package bp_profiler_pkg;

   localparam int bp_stall_reason_num_gp = 31;
   localparam int num_cnt_lp             = 34;

   typedef enum logic [4:0] {
      e_ic_miss      = 5'd0,
      e_br_ovr       = 5'd1,
      e_ret_ovr      = 5'd2,
      e_jal_ovr      = 5'd3,
      e_fe_cmd       = 5'd4,
      e_fe_cmd_fence = 5'd5,
      e_mispredict   = 5'd6,
      e_control_haz  = 5'd7,
      e_long_haz     = 5'd8,
      e_data_haz     = 5'd9,
      e_aux_dep      = 5'd10,
      e_load_dep     = 5'd11,
      e_mul_dep      = 5'd12,
      e_fma_dep      = 5'd13,
      e_sb_iraw_dep  = 5'd14,
      e_sb_fraw_dep  = 5'd15,
      e_sb_iwaw_dep  = 5'd16,
      e_sb_fwaw_dep  = 5'd17,
      e_struct_haz   = 5'd18,
      e_idiv_haz     = 5'd19,
      e_fdiv_haz     = 5'd20,
      e_ptw_busy     = 5'd21,
      e_special      = 5'd22,
      e_replay       = 5'd23,
      e_exception    = 5'd24,
      e_interrupt    = 5'd25,
      e_itlb_miss    = 5'd26,
      e_dtlb_miss    = 5'd27,
      e_dc_miss      = 5'd28,
      e_dc_fail      = 5'd29,
      e_unknown      = 5'd30
   } bp_stall_reason_e;

   // Field order mirrors the enum: code k sits at vector bit (30 - k).
   typedef struct packed {
      logic ic_miss;
      logic br_ovr;
      logic ret_ovr;
      logic jal_ovr;
      logic fe_cmd;
      logic fe_cmd_fence;
      logic mispredict;
      logic control_haz;
      logic long_haz;
      logic data_haz;
      logic aux_dep;
      logic load_dep;
      logic mul_dep;
      logic fma_dep;
      logic sb_iraw_dep;
      logic sb_fraw_dep;
      logic sb_iwaw_dep;
      logic sb_fwaw_dep;
      logic struct_haz;
      logic idiv_haz;
      logic fdiv_haz;
      logic ptw_busy;
      logic special;
      logic replay;
      logic exception;
      logic interrupt;
      logic itlb_miss;
      logic dtlb_miss;
      logic dc_miss;
      logic dc_fail;
      logic unknown;
   } bp_stall_reason_s;

   typedef enum logic [5:0] {
      e_cnt_commit = 6'd31,
      e_cnt_cycle  = 6'd32,
      e_cnt_multi  = 6'd33
   } bp_stall_cnt_addr_e;

   typedef struct packed {
      logic             v;
      logic             commit;
      logic             stall;
      logic             multi;
      bp_stall_reason_e code;
   } bp_stall_entry_s;

endpackage

// File: rtl/bp_stall_reason_decode.sv
// Combinational stall-reason decode: lowest set code wins, empty vector maps to unknown,
// and multi flags more than one reason asserted in the same cycle.
module bp_stall_reason_decode
   import bp_profiler_pkg::*;
(
   input  bp_stall_reason_s reason,
   output bp_stall_reason_e code,
   output logic             multi,
   output logic             any
);

   logic [bp_stall_reason_num_gp-1:0] vec;

   assign vec = reason;

   // Scan from the highest code down so the last hit, i.e. the lowest code, sticks.
   always_comb begin
      code = e_unknown;
      for (int k = bp_stall_reason_num_gp - 1; k >= 0; k--) begin
         if (vec[bp_stall_reason_num_gp - 1 - k]) code = bp_stall_reason_e'(5'(k));
      end
   end

   assign multi = ($countones(vec) > 1);
   assign any   = |vec;

endmodule

// File: rtl/bp_stall_profile_counters.sv
// Per-cycle stall-reason profiler: decode into a stage-1 entry, apply saturating increments
// to a flop counter bank one cycle later, and serve host reads through a valid/ready port.
module bp_stall_profile_counters
   import bp_profiler_pkg::*;
#(
   parameter int cnt_width_p  = 64,
   parameter int addr_width_p = 6
)
(
   input  logic                    aclk,
   input  logic                    aresetn,
   input  logic                    en_i,
   input  logic                    commit_v_i,
   input  logic                    stall_v_i,
   input  logic [30:0]             stall_reason_i,
   input  logic                    clear_i,
   input  logic                    rd_v_i,
   input  logic [addr_width_p-1:0] rd_addr_i,
   output logic                    rd_ready_o,
   output logic                    rd_data_v_o,
   output logic [cnt_width_p-1:0]  rd_data_o,
   output logic                    rd_err_o,
   input  logic                    rd_yumi_i,
   output logic                    sat_o
);

   bp_stall_reason_s reason;
   bp_stall_reason_e dec_code;
   logic             dec_multi;
   logic             dec_any;

   assign reason = bp_stall_reason_s'(stall_reason_i);

   bp_stall_reason_decode u_decode (
      .reason (reason),
      .code   (dec_code),
      .multi  (dec_multi),
      .any    (dec_any)
   );

   // ---------------- stage 1: capture the cycle's classification ----------------
   bp_stall_entry_s s1_d, s1_q;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      s1_d = '0;
      if (en_i && !clear_i) begin
         s1_d.v      = 1'b1;
         s1_d.commit = commit_v_i;
         s1_d.stall  = stall_v_i & ~commit_v_i;
         s1_d.multi  = stall_v_i & ~commit_v_i & dec_multi;
         s1_d.code   = dec_any ? dec_code : e_unknown;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) s1_q <= '0;
      else          s1_q <= s1_d;
   end

   // ---------------- stage 2: saturating counter bank ----------------
   logic [cnt_width_p-1:0] cnt_q [num_cnt_lp];
   logic [num_cnt_lp-1:0]  inc;
   logic [num_cnt_lp-1:0]  sat_hit;
   logic                   sat_q;

   always_comb begin
      inc = '0;
      if (s1_q.v) begin
         inc[e_cnt_cycle] = 1'b1;
         if (s1_q.commit) begin
            inc[e_cnt_commit] = 1'b1;
         end else if (s1_q.stall) begin
            inc[s1_q.code]   = 1'b1;
            inc[e_cnt_multi] = s1_q.multi;
         end
      end
   end

   // An increment landing on all-ones-minus-one or all-ones leaves the counter saturated.
   always_comb begin
      sat_hit = '0;
      for (int i = 0; i < num_cnt_lp; i++) begin
         sat_hit[i] = inc[i] & (&cnt_q[i][cnt_width_p-1:1]);
      end
   end

   // NOTE: the counter bank is host-visible architectural state, so unlike a data RAM it is reset.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < num_cnt_lp; i++) cnt_q[i] <= '0;
         sat_q <= 1'b0;
      end else if (clear_i) begin
         for (int i = 0; i < num_cnt_lp; i++) cnt_q[i] <= '0;
         sat_q <= 1'b0;
      end else begin
         for (int i = 0; i < num_cnt_lp; i++) begin
            if (inc[i] && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + cnt_width_p'(1);
         end
         if (|sat_hit) sat_q <= 1'b1;
      end
   end

   assign sat_o = sat_q;

   // ---------------- read port: samples the bank before this edge's increment ----------------
   logic rd_hit;
   logic rd_legal;

   assign rd_ready_o = ~rd_data_v_o | rd_yumi_i;
   assign rd_hit     = rd_v_i & rd_ready_o;
   assign rd_legal   = (rd_addr_i < addr_width_p'(num_cnt_lp));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_data_v_o <= 1'b0;
         rd_data_o   <= '0;
         rd_err_o    <= 1'b0;
      end else if (rd_hit) begin
         rd_data_v_o <= 1'b1;
         rd_err_o    <= ~rd_legal;
         rd_data_o   <= rd_legal ? cnt_q[rd_addr_i] : '0;
      end else if (rd_yumi_i) begin
         rd_data_v_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bp_stall_profile_counters.sv
// Directed bench for the stall profiler: a 64-bit instance for the functional tests, a 4-bit
// instance so saturation is reachable, and the reason decoder exercised on its own.
module tb_bp_stall_profile_counters;
   import bp_profiler_pkg::*;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        en, commit_v, stall_v, clear, rd_v, rd_yumi;
   logic [30:0] stall_reason;
   logic [5:0]  rd_addr;
   logic        rd_ready, rd_data_v, rd_err, sat;
   logic [63:0] rd_data;

   logic        en_s, clear_s, rd_v_s, rd_yumi_s;
   logic [5:0]  rd_addr_s;
   logic        rd_ready_s, rd_data_v_s, rd_err_s, sat_s;
   logic [3:0]  rd_data_s;

   logic [30:0]      dec_vec;
   bp_stall_reason_e dec_code;
   logic             dec_multi, dec_any;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [63:0] exp_cnt [34];

   localparam logic [30:0] bit_ic_miss  = 31'h4000_0000;
   localparam logic [30:0] bit_fence    = 31'h0200_0000;
   localparam logic [30:0] bit_dc_miss  = 31'h0000_0004;
   localparam logic [30:0] bit_dc_fail  = 31'h0000_0002;

   always #5 aclk = ~aclk;

   bp_stall_profile_counters dut (
      .aclk(aclk), .aresetn(aresetn), .en_i(en), .commit_v_i(commit_v), .stall_v_i(stall_v),
      .stall_reason_i(stall_reason), .clear_i(clear), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
      .rd_ready_o(rd_ready), .rd_data_v_o(rd_data_v), .rd_data_o(rd_data), .rd_err_o(rd_err),
      .rd_yumi_i(rd_yumi), .sat_o(sat)
   );

   bp_stall_profile_counters #(.cnt_width_p(4), .addr_width_p(6)) dut_s (
      .aclk(aclk), .aresetn(aresetn), .en_i(en_s), .commit_v_i(commit_v), .stall_v_i(stall_v),
      .stall_reason_i(stall_reason), .clear_i(clear_s), .rd_v_i(rd_v_s), .rd_addr_i(rd_addr_s),
      .rd_ready_o(rd_ready_s), .rd_data_v_o(rd_data_v_s), .rd_data_o(rd_data_s), .rd_err_o(rd_err_s),
      .rd_yumi_i(rd_yumi_s), .sat_o(sat_s)
   );

   bp_stall_reason_decode u_dec (
      .reason(dec_vec), .code(dec_code), .multi(dec_multi), .any(dec_any)
   );

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   // One read on the 64-bit instance: request, wait (bounded) for acceptance, consume.
   task automatic read_main(input logic [5:0] addr, output logic [63:0] data,
                            output logic err, output logic ok);
      int waited = 0;
      rd_v    = 1'b1;
      rd_addr = addr;
      while (!rd_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!rd_ready) begin
         rd_v = 1'b0;
         ok   = 1'b0;
         data = '0;
         err  = 1'b0;
      end else begin
         tick();
         rd_v    = 1'b0;
         ok      = rd_data_v;
         data    = rd_data;
         err     = rd_err;
         rd_yumi = 1'b1;
         tick();
         rd_yumi = 1'b0;
      end
   endtask

   task automatic run_stalls(input int cycles, input logic cm, input logic st, input logic [30:0] vec);
      en = 1'b1; commit_v = cm; stall_v = st; stall_reason = vec;
      repeat (cycles) tick();
      en = 1'b0; commit_v = 1'b0; stall_v = 1'b0; stall_reason = '0;
      tick();
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic        e, ok;
      aresetn = 1'b0;
      #2;
      n_cmp++;
      if (rd_ready !== 1'b1 || rd_data_v !== 1'b0 || rd_err !== 1'b0 || rd_data !== 64'd0 || sat !== 1'b0) begin
         n_err++;
         $display("FAIL reset_outputs: ready=%0b dv=%0b err=%0b data=%0h sat=%0b, want 1 0 0 0 0",
                  rd_ready, rd_data_v, rd_err, rd_data, sat);
      end
      repeat (2) @(posedge aclk);
      #1 aresetn = 1'b1;
      tick();
      for (int a = 0; a < 34; a++) begin
         read_main(6'(a), d, e, ok);
         n_cmp++;
         if (!ok || d !== 64'd0 || e !== 1'b0) begin
            n_err++;
            $display("FAIL reset_cnt[%0d]: got %0h v=%0b err=%0b, want 0 v=1 err=0", a, d, ok, e);
         end
      end
      read_main(6'd40, d, e, ok);
      n_cmp++;
      if (!ok || d !== 64'd0 || e !== 1'b1) begin
         n_err++;
         $display("FAIL reset_illegal_addr: got %0h v=%0b err=%0b, want 0 v=1 err=1", d, ok, e);
      end
   endtask

   task automatic test_decode();
      logic [30:0] vecs  [6] = '{31'h0, bit_dc_miss, bit_ic_miss | bit_dc_fail,
                                 bit_fence | bit_dc_miss, 31'h1, 31'h7FFF_FFFF};
      logic [4:0]  codes [6] = '{5'd30, 5'd28, 5'd0, 5'd5, 5'd30, 5'd0};
      logic        multis[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic        anys  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      for (int i = 0; i < 6; i++) begin
         dec_vec = vecs[i];
         #1;
         n_cmp++;
         if (5'(dec_code) !== codes[i] || dec_multi !== multis[i] || dec_any !== anys[i]) begin
            n_err++;
            $display("FAIL decode[%0d] vec=%0h: got code=%0d multi=%0b any=%0b, want %0d %0b %0b",
                     i, vecs[i], 5'(dec_code), dec_multi, dec_any, codes[i], multis[i], anys[i]);
         end
      end
   endtask

   task automatic test_single_reason();
      logic [63:0] d;
      logic        e, ok;
      run_stalls(10, 1'b0, 1'b1, bit_dc_miss);
      exp_cnt[28] += 10;
      exp_cnt[32] += 10;
      for (int a = 0; a < 34; a++) begin
         read_main(6'(a), d, e, ok);
         n_cmp++;
         if (!ok || d !== exp_cnt[a] || e !== 1'b0) begin
            n_err++;
            $display("FAIL single_cnt[%0d]: got %0h v=%0b err=%0b, want %0h", a, d, ok, e, exp_cnt[a]);
         end
      end
   endtask

   task automatic test_multi_and_unknown();
      logic [63:0] d;
      logic        e, ok;
      run_stalls(5, 1'b0, 1'b1, bit_ic_miss | bit_dc_fail);
      run_stalls(3, 1'b0, 1'b1, 31'h0);
      exp_cnt[0]  += 5;
      exp_cnt[33] += 5;
      exp_cnt[30] += 3;
      exp_cnt[32] += 8;
      for (int a = 0; a < 34; a++) begin
         read_main(6'(a), d, e, ok);
         n_cmp++;
         if (!ok || d !== exp_cnt[a] || e !== 1'b0) begin
            n_err++;
            $display("FAIL multi_cnt[%0d]: got %0h v=%0b err=%0b, want %0h", a, d, ok, e, exp_cnt[a]);
         end
      end
   endtask

   task automatic test_commit_priority();
      logic [63:0] d;
      logic        e, ok;
      run_stalls(4, 1'b1, 1'b1, bit_ic_miss | bit_dc_miss);
      exp_cnt[31] += 4;
      exp_cnt[32] += 4;
      for (int a = 0; a < 34; a++) begin
         read_main(6'(a), d, e, ok);
         n_cmp++;
         if (!ok || d !== exp_cnt[a] || e !== 1'b0) begin
            n_err++;
            $display("FAIL commit_cnt[%0d]: got %0h v=%0b err=%0b, want %0h", a, d, ok, e, exp_cnt[a]);
         end
      end
   endtask

   task automatic test_enable_low();
      logic [63:0] d;
      logic        e, ok;
      // One enabled sample, then inputs stay active with en low: only that sample counts.
      en = 1'b1; stall_v = 1'b1; stall_reason = bit_dc_miss;
      tick();
      en = 1'b0;
      repeat (3) tick();
      commit_v = 1'b1;
      repeat (3) tick();
      commit_v = 1'b0; stall_v = 1'b0; stall_reason = '0;
      tick();
      exp_cnt[28] += 1;
      exp_cnt[32] += 1;
      for (int a = 0; a < 34; a++) begin
         read_main(6'(a), d, e, ok);
         n_cmp++;
         if (!ok || d !== exp_cnt[a] || e !== 1'b0) begin
            n_err++;
            $display("FAIL en_low_cnt[%0d]: got %0h v=%0b err=%0b, want %0h", a, d, ok, e, exp_cnt[a]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [5:0]  addrs [5] = '{6'd28, 6'd0, 6'd31, 6'd40, 6'd30};
      logic [63:0] want;
      logic        want_err;
      rd_v    = 1'b1;
      rd_yumi = 1'b1;
      for (int i = 0; i < 5; i++) begin
         rd_addr = addrs[i];
         tick();
         want     = (addrs[i] < 6'd34) ? exp_cnt[addrs[i]] : 64'd0;
         want_err = (addrs[i] >= 6'd34);
         n_cmp++;
         if (rd_data_v !== 1'b1 || rd_ready !== 1'b1 || rd_data !== want || rd_err !== want_err) begin
            n_err++;
            $display("FAIL b2b[%0d] addr=%0d: got v=%0b rdy=%0b data=%0h err=%0b, want 1 1 %0h %0b",
                     i, addrs[i], rd_data_v, rd_ready, rd_data, rd_err, want, want_err);
         end
      end
      rd_v = 1'b0;
      tick();
      rd_yumi = 1'b0;
      n_cmp++;
      if (rd_data_v !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_drain: got v=%0b, want 0", rd_data_v);
      end
   endtask

   task automatic test_clear();
      logic [63:0] d, pre;
      logic        e, ok;
      // At the clear edge the first sample has landed, the second is in flight and gets lost.
      pre = exp_cnt[28] + 64'd1;
      en = 1'b1; stall_v = 1'b1; stall_reason = bit_dc_miss;
      tick();
      tick();
      clear = 1'b1; rd_v = 1'b1; rd_addr = 6'd28;
      tick();
      clear = 1'b0; rd_v = 1'b0;
      n_cmp++;
      if (rd_data_v !== 1'b1 || rd_data !== pre || rd_err !== 1'b0) begin
         n_err++;
         $display("FAIL clear_preread: got v=%0b data=%0h err=%0b, want 1 %0h 0", rd_data_v, rd_data, rd_err, pre);
      end
      rd_yumi = 1'b1;
      tick();
      rd_yumi = 1'b0;
      tick();
      tick();
      en = 1'b0; stall_v = 1'b0; stall_reason = '0;
      tick();
      for (int a = 0; a < 34; a++) exp_cnt[a] = '0;
      exp_cnt[28] = 64'd3;
      exp_cnt[32] = 64'd3;
      for (int a = 0; a < 34; a++) begin
         read_main(6'(a), d, e, ok);
         n_cmp++;
         if (!ok || d !== exp_cnt[a] || e !== 1'b0) begin
            n_err++;
            $display("FAIL clear_cnt[%0d]: got %0h v=%0b err=%0b, want %0h", a, d, ok, e, exp_cnt[a]);
         end
      end
      n_cmp++;
      if (sat !== 1'b0) begin
         n_err++;
         $display("FAIL clear_sat: got %0b, want 0", sat);
      end
   endtask

   // 4-bit counters: 14 fence stalls bring counter 5 to all-ones-minus-one, 3 more saturate it.
   task automatic test_saturation();
      en_s = 1'b1; stall_v = 1'b1; stall_reason = bit_fence;
      repeat (14) tick();
      en_s = 1'b0; stall_v = 1'b0; stall_reason = '0;
      tick();
      rd_v_s = 1'b1; rd_addr_s = 6'd5;
      tick();
      rd_v_s = 1'b0;
      n_cmp++;
      if (rd_data_v_s !== 1'b1 || rd_data_s !== 4'd14 || sat_s !== 1'b0) begin
         n_err++;
         $display("FAIL sat_pre: got v=%0b data=%0d sat=%0b, want 1 14 0", rd_data_v_s, rd_data_s, sat_s);
      end
      rd_yumi_s = 1'b1;
      tick();
      rd_yumi_s = 1'b0;
      en_s = 1'b1; stall_v = 1'b1; stall_reason = bit_fence;
      repeat (3) tick();
      en_s = 1'b0; stall_v = 1'b0; stall_reason = '0;
      tick();
      n_cmp++;
      if (sat_s !== 1'b1) begin
         n_err++;
         $display("FAIL sat_flag: got %0b, want 1", sat_s);
      end
      rd_v_s = 1'b1; rd_addr_s = 6'd5;
      tick();
      n_cmp++;
      if (rd_data_v_s !== 1'b1 || rd_data_s !== 4'd15) begin
         n_err++;
         $display("FAIL sat_value: got v=%0b data=%0d, want 1 15", rd_data_v_s, rd_data_s);
      end
      rd_addr_s = 6'd0;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++;
         if (rd_data_v_s !== 1'b1 || rd_data_s !== 4'd15 || rd_ready_s !== 1'b0) begin
            n_err++;
            $display("FAIL sat_hold[%0d]: got v=%0b data=%0d rdy=%0b, want 1 15 0",
                     i, rd_data_v_s, rd_data_s, rd_ready_s);
         end
      end
      rd_yumi_s = 1'b1;
      tick();
      rd_v_s = 1'b0;
      n_cmp++;
      if (rd_data_v_s !== 1'b1 || rd_data_s !== 4'd0) begin
         n_err++;
         $display("FAIL sat_release: got v=%0b data=%0d, want 1 0", rd_data_v_s, rd_data_s);
      end
      tick();
      rd_yumi_s = 1'b0;
      clear_s = 1'b1;
      tick();
      clear_s = 1'b0;
      n_cmp++;
      if (sat_s !== 1'b0) begin
         n_err++;
         $display("FAIL sat_clear: got %0b, want 0", sat_s);
      end
   endtask

   task automatic test_reset_mid_read();
      logic [63:0] d;
      logic        e, ok;
      rd_v = 1'b1; rd_addr = 6'd28;
      tick();
      rd_v = 1'b0;
      n_cmp++;
      if (rd_data_v !== 1'b1 || rd_data !== exp_cnt[28]) begin
         n_err++;
         $display("FAIL rst_read_issue: got v=%0b data=%0h, want 1 %0h", rd_data_v, rd_data, exp_cnt[28]);
      end
      #2 aresetn = 1'b0;
      #1;
      n_cmp++;
      if (rd_data_v !== 1'b0 || rd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_read_drop: got v=%0b rdy=%0b, want 0 1", rd_data_v, rd_ready);
      end
      @(posedge aclk);
      #1 aresetn = 1'b1;
      tick();
      read_main(6'd28, d, e, ok);
      n_cmp++;
      if (!ok || d !== 64'd0 || e !== 1'b0) begin
         n_err++;
         $display("FAIL rst_read_after: got %0h v=%0b err=%0b, want 0", d, ok, e);
      end
   endtask

   initial begin
      en = 1'b0; commit_v = 1'b0; stall_v = 1'b0; stall_reason = '0; clear = 1'b0;
      rd_v = 1'b0; rd_addr = '0; rd_yumi = 1'b0;
      en_s = 1'b0; clear_s = 1'b0; rd_v_s = 1'b0; rd_addr_s = '0; rd_yumi_s = 1'b0;
      dec_vec = '0;
      for (int a = 0; a < 34; a++) exp_cnt[a] = '0;

      test_reset();
      test_decode();
      test_single_reason();
      test_multi_and_unknown();
      test_commit_priority();
      test_enable_low();
      test_back_to_back();
      test_clear();
      test_saturation();
      test_reset_mid_read();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule
